// File: rtl/spm_seq.sv
// Self-sequencing serial-parallel multiplier: accepts x/y over a handshake, streams the
// product LSB first through an XW-cell carry-save array and returns it in parallel.
module spm_seq #(
  parameter int unsigned XW = 32,
  parameter int unsigned YW = 32,
  localparam int unsigned PW = XW + YW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  logic          signed_mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] p,
  output logic          busy
);

  localparam int unsigned CW = $clog2(PW + 2);
  localparam logic [CW-1:0] Last = CW'(PW + 1);
  localparam logic [CW-1:0] YLim = CW'(YW);
  localparam logic [CW-1:0] One  = CW'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XW-1:0] xm_q, xm_d;
  logic [YW-1:0] yr_q, yr_d;
  logic          yneg_q, yneg_d;
  logic          neg_q, neg_d;
  logic          ycs_q, ycs_d;
  logic          ocs_q, ocs_d;
  logic          ob_q, ob_d;
  logic [XW-1:0] s_q, s_d;
  logic [XW-1:0] c_q, c_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [PW-1:0] p_q, p_d;

  logic          y_active;
  logic          yin;
  logic [XW:0]   s_ext;
  logic [XW-1:0] arr_s, arr_c;

  // Multiplier stream: |y| LSB first, then zeros (complementer gated off after YW bits).
  always_comb begin
    y_active = (cnt_q < YLim);
    yin      = y_active ? (yr_q[0] ^ (yneg_q & ycs_q)) : 1'b0;
  end

  // Carry-save cells: sums move one cell toward the LSB per clock, carries stay in place.
  always_comb begin
    s_ext = {1'b0, s_q};
    arr_s = '0;
    arr_c = '0;
    for (int i = 0; i < int'(XW); i++) begin
      arr_s[i] = (xm_q[i] & yin) ^ s_ext[i+1] ^ c_q[i];
      arr_c[i] = ((xm_q[i] & yin) & s_ext[i+1]) | ((xm_q[i] & yin) & c_q[i]) |
                 (s_ext[i+1] & c_q[i]);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    xm_d    = xm_q;
    yr_d    = yr_q;
    yneg_d  = yneg_q;
    neg_d   = neg_q;
    ycs_d   = ycs_q;
    ocs_d   = ocs_q;
    ob_d    = ob_q;
    s_d     = s_q;
    c_d     = c_q;
    acc_d   = acc_q;
    p_d     = p_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = StRun;
          cnt_d   = '0;
          xm_d    = (signed_mode & x[XW-1]) ? (~x + 1'b1) : x;
          yr_d    = y;
          yneg_d  = signed_mode & y[YW-1];
          neg_d   = signed_mode & (x[XW-1] ^ y[YW-1]);
          ycs_d   = 1'b0;
          ocs_d   = 1'b0;
          ob_d    = 1'b0;
          s_d     = '0;
          c_d     = '0;
          acc_d   = '0;
        end
      end
      StRun: begin
        cnt_d = cnt_q + One;
        yr_d  = yr_q >> 1;
        if (y_active) ycs_d = ycs_q | yr_q[0];
        s_d = arr_s;
        c_d = arr_c;
        // cnt 0 sees the bubble; product bit k leaves the array at cnt k+1
        if (cnt_q != '0) begin
          ob_d  = s_q[0] ^ (neg_q & ocs_q);
          ocs_d = ocs_q | s_q[0];
        end
        if (cnt_q > One) acc_d = {ob_q, acc_q[PW-1:1]};
        if (cnt_q == Last) begin
          p_d     = {ob_q, acc_q[PW-1:1]};
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      xm_q    <= '0;
      yr_q    <= '0;
      yneg_q  <= 1'b0;
      neg_q   <= 1'b0;
      ycs_q   <= 1'b0;
      ocs_q   <= 1'b0;
      ob_q    <= 1'b0;
      s_q     <= '0;
      c_q     <= '0;
      acc_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      xm_q    <= xm_d;
      yr_q    <= yr_d;
      yneg_q  <= yneg_d;
      neg_q   <= neg_d;
      ycs_q   <= ycs_d;
      ocs_q   <= ocs_d;
      ob_q    <= ob_d;
      s_q     <= s_d;
      c_q     <= c_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
    p         = p_q;
  end

endmodule

// File: tb/tb_spm_seq.sv
// Bench for spm_seq: an 8x8 instance for directed corners and a 32x32 instance for random
// operands, both compared against plain integer multiplication.
module tb_spm_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        iv8, ir8, sm8, ov8, or8, busy8;
  logic [7:0]  x8, y8;
  logic [15:0] p8;
  logic        iv32, ir32, sm32, ov32, or32, busy32;
  logic [31:0] x32, y32;
  logic [63:0] p32;

  int total = 0;
  int bad = 0;

  spm_seq #(.XW(8), .YW(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .x(x8), .y(y8),
    .signed_mode(sm8), .out_valid(ov8), .out_ready(or8), .p(p8), .busy(busy8)
  );

  spm_seq u32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .x(x32), .y(y32),
    .signed_mode(sm32), .out_valid(ov32), .out_ready(or32), .p(p32), .busy(busy32)
  );

  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b,
                                       input logic sm);
    logic [15:0] ea, eb;
    ea = sm ? {{8{a[7]}}, a} : {8'h00, a};
    eb = sm ? {{8{b[7]}}, b} : {8'h00, b};
    return ea * eb;
  endfunction

  function automatic logic [63:0] ref32(input logic [31:0] a, input logic [31:0] b,
                                        input logic sm);
    logic [63:0] ea, eb;
    ea = sm ? {{32{a[31]}}, a} : {32'h0, a};
    eb = sm ? {{32{b[31]}}, b} : {32'h0, b};
    return ea * eb;
  endfunction

  // One complete 8-bit operation; leak flags any in_ready/busy/out_valid misbehaviour.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                      input int stall, output logic [15:0] pr, output int lat,
                      output bit leak, output time tacc);
    x8 = a; y8 = b; sm8 = sm; or8 = (stall == 0); iv8 = 1'b1;
    leak = (ir8 !== 1'b1);
    @(posedge clk);
    tacc = $time;
    #1 iv8 = 1'b0;
    lat = 0;
    while (ov8 !== 1'b1 && lat < 200) begin
      if (ir8 !== 1'b0 || busy8 !== 1'b1) leak = 1;
      @(posedge clk);
      #1 lat++;
    end
    if (ir8 !== 1'b0 || busy8 !== 1'b1) leak = 1;
    repeat (stall) begin
      @(posedge clk);
      #1;
      if (ov8 !== 1'b1 || ir8 !== 1'b0) leak = 1;
    end
    pr = p8;
    or8 = 1'b1;
    @(posedge clk);
    #1 or8 = 1'b0;
  endtask

  task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic sm,
                       input int stall, output logic [63:0] pr, output int lat);
    x32 = a; y32 = b; sm32 = sm; or32 = (stall == 0); iv32 = 1'b1;
    @(posedge clk);
    #1 iv32 = 1'b0;
    lat = 0;
    while (ov32 !== 1'b1 && lat < 300) begin
      @(posedge clk);
      #1 lat++;
    end
    repeat (stall) @(posedge clk);
    #1;
    pr = p32;
    or32 = 1'b1;
    @(posedge clk);
    #1 or32 = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0 || busy8 !== 1'b0 || p8 !== 16'h0) begin
      bad++;
      $display("FAIL reset8: got ir=%b ov=%b busy=%b p=%h want 1 0 0 0000", ir8, ov8, busy8, p8);
    end
    total++;
    if (ir32 !== 1'b1 || ov32 !== 1'b0 || busy32 !== 1'b0 || p32 !== 64'h0) begin
      bad++;
      $display("FAIL reset32: got ir=%b ov=%b busy=%b p=%h want 1 0 0 0", ir32, ov32, busy32, p32);
    end
  endtask

  task automatic test_unsigned_max();
    logic [15:0] pr; int lat; bit leak; time t;
    run8(8'hFF, 8'hFF, 1'b0, 0, pr, lat, leak, t);
    total++;
    if (lat !== 18) begin bad++; $display("FAIL latency8: got %0d want 18", lat); end
    total++;
    if (pr !== 16'hFE01) begin bad++; $display("FAIL umax: got %h want fe01", pr); end
    total++;
    if (leak) begin bad++; $display("FAIL handshake8: got leak=1 want 0"); end
    total++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0 || p8 !== 16'hFE01) begin
      bad++;
      $display("FAIL post_hs: got ir=%b ov=%b p=%h want 1 0 fe01", ir8, ov8, p8);
    end
  endtask

  task automatic test_signed_corners();
    logic [7:0] xa [7] = '{8'h80, 8'h80, 8'hFD, 8'h00, 8'h00, 8'h5A, 8'h5A};
    logic [7:0] ya [7] = '{8'h80, 8'h01, 8'h07, 8'hA5, 8'hA5, 8'h00, 8'h00};
    logic       sa [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [15:0] ea [7] = '{16'h4000, 16'hFF80, 16'hFFEB, 16'h0, 16'h0, 16'h0, 16'h0};
    logic [15:0] pr; int lat; bit leak; time t;
    for (int i = 0; i < 7; i++) begin
      run8(xa[i], ya[i], sa[i], 0, pr, lat, leak, t);
      total++;
      if (pr !== ea[i] || lat !== 18) begin
        bad++;
        $display("FAIL corner%0d: got p=%h lat=%0d want p=%h lat=18", i, pr, lat, ea[i]);
      end
    end
  endtask

  task automatic test_random8();
    logic [7:0] a, b; logic sm; logic [15:0] pr; int lat; bit leak; time t;
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom); b = 8'($urandom); sm = 1'($urandom);
      run8(a, b, sm, int'($urandom_range(0, 2)), pr, lat, leak, t);
      total++;
      if (pr !== ref8(a, b, sm) || leak) begin
        bad++;
        $display("FAIL rand8: got p=%h leak=%b want p=%h (x=%h y=%h s=%b)",
                 pr, leak, ref8(a, b, sm), a, b, sm);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] held; int lat;
    x8 = 8'h37; y8 = 8'hC9; sm8 = 1'b1; or8 = 1'b0; iv8 = 1'b1;
    @(posedge clk);
    #1 iv8 = 1'b0;
    lat = 0;
    while (ov8 !== 1'b1 && lat < 200) begin @(posedge clk); #1 lat++; end
    held = p8;
    total++;
    if (held !== ref8(8'h37, 8'hC9, 1'b1)) begin
      bad++;
      $display("FAIL bp_value: got %h want %h", held, ref8(8'h37, 8'hC9, 1'b1));
    end
    for (int i = 0; i < 10; i++) begin
      iv8 = i[0]; x8 = 8'($urandom); y8 = 8'($urandom);
      @(posedge clk);
      #1;
      total++;
      if (ov8 !== 1'b1 || ir8 !== 1'b0 || p8 !== held) begin
        bad++;
        $display("FAIL bp_hold%0d: got ov=%b ir=%b p=%h want 1 0 %h", i, ov8, ir8, p8, held);
      end
    end
    iv8 = 1'b0; or8 = 1'b1;
    @(posedge clk);
    #1 or8 = 1'b0;
    total++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0 || p8 !== held) begin
      bad++;
      $display("FAIL bp_release: got ir=%b ov=%b p=%h want 1 0 %h", ir8, ov8, p8, held);
    end
    @(posedge clk);
    #1;
    total++;
    if (ir8 !== 1'b1 || busy8 !== 1'b0) begin
      bad++;
      $display("FAIL bp_idle: got ir=%b busy=%b want 1 0", ir8, busy8);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] p1, p2; int l1, l2; bit k1, k2; time t1, t2;
    run8(8'h0C, 8'h0B, 1'b0, 0, p1, l1, k1, t1);
    run8(8'hF6, 8'h05, 1'b1, 0, p2, l2, k2, t2);
    total++;
    if (t2 - t1 !== 200) begin bad++; $display("FAIL b2b_spacing: got %0t want 200", t2 - t1); end
    total++;
    if (p1 !== 16'd132 || p2 !== 16'hFFCE || k1 || k2) begin
      bad++;
      $display("FAIL b2b_values: got %h %h leak=%b%b want 0084 ffce 00", p1, p2, k1, k2);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] pr; int lat; bit leak; time t;
    x8 = 8'hA7; y8 = 8'h6B; sm8 = 1'b0; or8 = 1'b1; iv8 = 1'b1;
    @(posedge clk);
    #1 iv8 = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    total++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0 || p8 !== 16'h0 || busy8 !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: got ir=%b ov=%b busy=%b p=%h want 1 0 0 0000", ir8, ov8, busy8, p8);
    end
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    run8(8'd3, 8'd5, 1'b0, 0, pr, lat, leak, t);
    total++;
    if (pr !== 16'd15 || lat !== 18) begin
      bad++;
      $display("FAIL after_reset: got p=%h lat=%0d want 000f 18", pr, lat);
    end
  endtask

  task automatic test_random32();
    logic [31:0] corner [5] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h7FFF_FFFF};
    logic [31:0] a, b; logic sm; logic [63:0] pr; int lat, stall;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom; b = $urandom; sm = 1'($urandom);
      if ($urandom_range(0, 7) == 0) a = corner[$urandom_range(0, 4)];
      if ($urandom_range(0, 7) == 0) b = corner[$urandom_range(0, 4)];
      stall = int'($urandom_range(0, 2));
      run32(a, b, sm, stall, pr, lat);
      total++;
      if (pr !== ref32(a, b, sm) || lat !== 66) begin
        bad++;
        $display("FAIL rand32: got p=%h lat=%0d want p=%h lat=66 (x=%h y=%h s=%b)",
                 pr, lat, ref32(a, b, sm), a, b, sm);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    iv8 = 1'b0; x8 = '0; y8 = '0; sm8 = 1'b0; or8 = 1'b0;
    iv32 = 1'b0; x32 = '0; y32 = '0; sm32 = 1'b0; or32 = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_unsigned_max();
    test_signed_corners();
    test_random8();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    test_random32();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
